// File: rtl/count_sequencer.sv
// Start/stop/pause sequencer around a WIDTH-bit up-counter with one-shot or periodic terminal count.
// Optional count prescaler enabled by defining COUNT_SEQUENCER_PRESCALE_EN.
module count_sequencer #(
  parameter int WIDTH        = 4,
  parameter int PRESCALE_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] count_r, count_s;
  logic [WIDTH-1:0] limit_r, limit_s;
  logic             mode_r, mode_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             tc_r, tc_s;
  logic             tick_s;

`ifdef COUNT_SEQUENCER_PRESCALE_EN
  localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  logic [PW-1:0] presc_r, presc_s;

  // advance only on the last prescaler phase
  assign tick_s = (presc_r == PW'(PRESCALE_DIV - 1));

  // prescaler phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_s;
    end
  end
`else
  // prescaler bypassed: every unpaused RUN cycle advances, divide value has no effect
  assign tick_s = (PRESCALE_DIV != 0) | 1'b1;
`endif

  // next-state, datapath and output pulse decode
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    limit_s = limit_r;
    mode_s  = mode_r;
    done_s  = 1'b0;
    tc_s    = 1'b0;
`ifdef COUNT_SEQUENCER_PRESCALE_EN
    presc_s = presc_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start && !stop) begin
          state_s = ST_RUN;
          count_s = {WIDTH{1'b0}};
          limit_s = limit;
          mode_s  = mode;
`ifdef COUNT_SEQUENCER_PRESCALE_EN
          presc_s = {PW{1'b0}};
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_s = ST_IDLE;
          count_s = {WIDTH{1'b0}};
`ifdef COUNT_SEQUENCER_PRESCALE_EN
          presc_s = {PW{1'b0}};
`endif
        end else if (pause) begin
          state_s = ST_HOLD;
        end else if (tick_s) begin
`ifdef COUNT_SEQUENCER_PRESCALE_EN
          presc_s = {PW{1'b0}};
`endif
          // terminal reached: wrap only through this rule, never by overflow
          if (count_r == limit_r) begin
            if (mode_r) begin
              count_s = {WIDTH{1'b0}};
              tc_s    = 1'b1;
            end else begin
              done_s  = 1'b1;
              state_s = ST_IDLE;
            end
          end else begin
            count_s = count_r + WIDTH'(1);
          end
        end else begin
`ifdef COUNT_SEQUENCER_PRESCALE_EN
          presc_s = presc_r + PW'(1);
`endif
        end
      end
      ST_HOLD: begin
        if (stop) begin
          state_s = ST_IDLE;
          count_s = {WIDTH{1'b0}};
`ifdef COUNT_SEQUENCER_PRESCALE_EN
          presc_s = {PW{1'b0}};
`endif
        end else if (!pause) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
        count_s = {WIDTH{1'b0}};
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // state, count, latched configuration and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      count_r <= {WIDTH{1'b0}};
      limit_r <= {WIDTH{1'b0}};
      mode_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      tc_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      limit_r <= limit_s;
      mode_r  <= mode_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      tc_r    <= tc_s;
    end
  end

  assign count = count_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign tc    = tc_r;

endmodule

// File: tb/tb_count_sequencer.sv
// Table-driven, scoreboard-checked bench for count_sequencer (WIDTH=4, PRESCALE_DIV=4).
module tb_count_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start, stop, pause, mode;
  logic [3:0] limit;
  logic [3:0] count;
  logic       busy, done, tc;

  count_sequencer #(.WIDTH(4), .PRESCALE_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .limit(limit), .count(count), .busy(busy), .done(done), .tc(tc)
  );

  typedef struct {
    logic       start, stop, pause, mode;
    logic [3:0] limit;
    logic [3:0] count;
    logic       busy, done, tc;
  } vec_t;

  typedef struct {
    int         id;
    logic [3:0] count;
    logic       busy, done, tc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic s, p, ps, m, input logic [3:0] lim,
                     input logic [3:0] c, input logic b, d, t);
    vec_t v;
    v.start = s; v.stop = p; v.pause = ps; v.mode = m; v.limit = lim;
    v.count = c; v.busy = b; v.done = d; v.tc = t;
    tbl.push_back(v);
  endtask

  task automatic push_exp(input int id, input logic [3:0] c, input logic b, d, t);
    exp_t e;
    e.id = id; e.count = c; e.busy = b; e.done = d; e.tc = t;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: no expected entry for DUT output");
    end else begin
      e = sb.pop_front();
      if (count !== e.count || busy !== e.busy || done !== e.done || tc !== e.tc) begin
        n_err++;
        $display("FAIL vec%0d: got count=%0d busy=%b done=%b tc=%b, want count=%0d busy=%b done=%b tc=%b",
                 e.id, count, busy, done, tc, e.count, e.busy, e.done, e.tc);
      end
    end
  endtask

  task automatic step(input int id, input logic s, p, ps, m, input logic [3:0] lim,
                      input logic [3:0] c, input logic b, d, t);
    start = s; stop = p; pause = ps; mode = m; limit = lim;
    push_exp(id, c, b, d, t);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0; limit = 4'd0;
    rst_n = 1'b0;
    #12;
    push_exp(1000, 4'd0, 1'b0, 1'b0, 1'b0);
    check_out();
    @(negedge clk);
    rst_n = 1'b1;

`ifndef COUNT_SEQUENCER_PRESCALE_EN
    // one-shot limit=3; mid-run limit/mode changes ignored
    add(1,0,0,0,4'd3, 4'd0,1,0,0);
    add(0,0,0,0,4'd7, 4'd1,1,0,0);
    add(0,0,0,1,4'd7, 4'd2,1,0,0);
    add(0,0,0,0,4'd3, 4'd3,1,0,0);
    add(0,0,0,0,4'd3, 4'd3,0,1,0);
    // start while done high: periodic limit=2, 9 advances
    add(1,0,0,1,4'd2, 4'd0,1,0,0);
    add(0,0,0,1,4'd2, 4'd1,1,0,0);
    add(0,0,0,1,4'd2, 4'd2,1,0,0);
    add(0,0,0,1,4'd2, 4'd0,1,0,1);
    add(1,0,0,0,4'd9, 4'd1,1,0,0);
    add(0,0,0,1,4'd2, 4'd2,1,0,0);
    add(0,0,0,1,4'd2, 4'd0,1,0,1);
    add(0,0,0,1,4'd2, 4'd1,1,0,0);
    add(0,0,0,1,4'd2, 4'd2,1,0,0);
    add(0,0,0,1,4'd2, 4'd0,1,0,1);
    add(0,1,0,0,4'd2, 4'd0,0,0,0);
    add(0,1,0,0,4'd2, 4'd0,0,0,0);
    add(1,1,0,0,4'd5, 4'd0,0,0,0);
    // pause 3 cycles at 2, resume, stop at 4
    add(1,0,0,0,4'd9, 4'd0,1,0,0);
    add(0,0,0,0,4'd9, 4'd1,1,0,0);
    add(0,0,0,0,4'd9, 4'd2,1,0,0);
    add(0,0,1,0,4'd9, 4'd2,1,0,0);
    add(0,0,1,0,4'd9, 4'd2,1,0,0);
    add(0,0,1,0,4'd9, 4'd2,1,0,0);
    add(0,0,0,0,4'd9, 4'd2,1,0,0);
    add(0,0,0,0,4'd9, 4'd3,1,0,0);
    add(0,0,0,0,4'd9, 4'd4,1,0,0);
    add(0,1,0,0,4'd9, 4'd0,0,0,0);
    // pause on terminal cycle, periodic limit=1
    add(1,0,0,1,4'd1, 4'd0,1,0,0);
    add(0,0,0,1,4'd1, 4'd1,1,0,0);
    add(0,0,1,1,4'd1, 4'd1,1,0,0);
    add(0,0,0,1,4'd1, 4'd1,1,0,0);
    add(0,0,0,1,4'd1, 4'd0,1,0,1);
    add(0,1,0,1,4'd1, 4'd0,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(i, tbl[i].start, tbl[i].stop, tbl[i].pause, tbl[i].mode, tbl[i].limit,
           tbl[i].count, tbl[i].busy, tbl[i].done, tbl[i].tc);
    end

    // asynchronous reset mid-run at count=5
    step(100, 1,0,0,0,4'd9, 4'd0,1,0,0);
    for (int k = 1; k <= 5; k++) step(100 + k, 0,0,0,0,4'd9, 4'(k),1,0,0);
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(110, 4'd0, 1'b0, 1'b0, 1'b0);
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    step(111, 0,0,0,0,4'd9, 4'd0,0,0,0);

    // full-range one-shot, limit=15
    step(200, 1,0,0,0,4'd15, 4'd0,1,0,0);
    for (int k = 1; k <= 15; k++) step(200 + k, 0,0,0,0,4'd15, 4'(k),1,0,0);
    step(216, 0,0,0,0,4'd15, 4'd15,0,1,0);

    // limit=0 periodic: tc every cycle
    step(300, 1,0,0,1,4'd0, 4'd0,1,0,0);
    for (int k = 1; k <= 4; k++) step(300 + k, 0,0,0,1,4'd0, 4'd0,1,0,1);
    step(305, 0,1,0,1,4'd0, 4'd0,0,0,0);

    // limit=0 one-shot: done after edge 1
    step(310, 1,0,0,0,4'd0, 4'd0,1,0,0);
    step(311, 0,0,0,0,4'd0, 4'd0,0,1,0);
`else
    // prescaled one-shot, limit=1, divide by 4
    step(400, 1,0,0,0,4'd1, 4'd0,1,0,0);
    for (int k = 1; k <= 3; k++) step(400 + k, 0,0,0,0,4'd1, 4'd0,1,0,0);
    step(404, 0,0,0,0,4'd1, 4'd1,1,0,0);
    for (int k = 5; k <= 7; k++) step(400 + k, 0,0,0,0,4'd1, 4'd1,1,0,0);
    step(408, 0,0,0,0,4'd1, 4'd1,0,1,0);
    step(409, 0,0,0,0,4'd1, 4'd1,0,0,0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Controller that sequences a WIDTH-bit up-counter: start/stop/pause control, terminal-count compare, one-shot or periodic (auto-reload) operation.
- Gives the counter datapath a handshake-driven front end, so higher-level modules can launch timed intervals and receive a done/terminal-count event instead of free-running ripple stages.
- Single clock domain; the count register lives inside the block.

Parameters:
WIDTH, 4, counter and limit width in bits
PRESCALE_DIV, 4, clock cycles per count advance when PRESCALE_EN is defined (>=2); ignored otherwise

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  launch request, sampled in IDLE only
stop  input  1  abort; highest priority
pause  input  1  level: freeze count while high (RUN/HOLD only)
mode  input  1  0 = one-shot, 1 = periodic; latched at start
limit  input  WIDTH  terminal value; latched at start
count  output  WIDTH  current count value
busy  output  1  high in RUN and HOLD
done  output  1  one-cycle pulse: one-shot interval complete
tc  output  1  one-cycle pulse: periodic wrap at terminal count

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-low, named rst_n. While rst_n=0: state=IDLE, count=0, busy=0, done=0, tc=0, latched limit/mode=0. Release takes effect at the first clk edge with rst_n=1.
- All outputs are registered; no combinational input-to-output paths.
- States:
  - IDLE: busy=0.
  - RUN: advancing.
  - HOLD: paused.
- Transitions:
  - IDLE -> RUN: start=1 and stop=0. On that edge: count<=0; limit and mode are latched.
  - RUN -> HOLD: pause=1.
  - HOLD -> RUN: pause=0.
  - RUN/HOLD -> IDLE: stop=1. On that edge: count<=0; no done or tc.
  - RUN -> IDLE: one-shot terminal.
- Priority per edge: stop > pause > terminal/advance. start is ignored outside IDLE (no restart). stop in IDLE has no effect. start+stop together in IDLE: stay IDLE.
- Advance: occurs on every RUN edge with pause=0 (see Optional Feature for prescaling).
  - If count != latched limit: count <= count+1.
  - If count == latched limit (terminal):
    - One-shot: count holds at limit, done=1 for the next cycle, state -> IDLE.
    - Periodic: count <= 0, tc=1 for the next cycle, stay RUN.
- Timing: for start sampled at edge 0, count=k after edge k (k<=L, L = limit). One-shot done is high after edge L+1. Periodic period = L+1 advances.
- limit=0: count stays 0; one-shot done after edge 1; periodic tc after every advance.
- limit = 2^WIDTH-1: full-range count, no overflow. Arithmetic is modulo 2^WIDTH, but wrap occurs only via the terminal rule.
- Pause on the terminal cycle: no advance, no done/tc; terminal is re-evaluated after resume.
- Mid-run changes to limit/mode are ignored until the next start.
- Start in the same cycle done is high (state IDLE): accepted; new run begins and done clears next cycle.
- Reset mid-run: immediate return to IDLE with all outputs 0, regardless of clk.

Optional Feature:
- Macro: COUNT_SEQUENCER_PRESCALE_EN.
- Defined: an internal prescaler counts RUN, unpaused cycles. An advance happens only when the prescaler reaches PRESCALE_DIV-1, after which the prescaler returns to 0.
  - Prescaler clears on start, stop and reset; it freezes in HOLD.
  - One-shot done follows (L+1)*PRESCALE_DIV cycles after start.
- Not defined: every RUN, unpaused cycle advances; no prescaler logic exists.

Test Plan:
- Reset: rst_n low mid-RUN at count=5, asynchronous to clk -> count=0, busy=0, done=0, tc=0 immediately; IDLE after release.
- One-shot: limit=3, mode=0, start pulse at edge 0 -> count 1,2,3 after edges 1-3; done=1 for exactly one cycle after edge 4; busy=0 and count=3 after edge 4.
- Periodic: limit=2, mode=1, run 9 advances -> count sequence 1,2,0,1,2,0,1,2,0; tc pulses after advances 3, 6, 9; done never asserts.
- Pause/stop: pause held 3 cycles at count=2 -> count stays 2, busy=1; pause released then stop at count=4 -> IDLE, count=0, no done; start+stop together in IDLE -> stays IDLE.
- Boundary: WIDTH=4, limit=15, one-shot -> count reaches 15, done after edge 16. limit=0, periodic -> tc every cycle, count=0.
- With COUNT_SEQUENCER_PRESCALE_EN, PRESCALE_DIV=4, limit=1, one-shot -> count=1 after edge 4; done after edge 8.
